// File: rtl/regfile_sb.sv
// regfile_sb: register file with registered write-first read ports and a per-register busy scoreboard
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ZERO_REG = 0,
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           addr_a,
  input  logic [AW-1:0]           addr_b,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic signed [WIDTH-1:0] data_a,
  output logic signed [WIDTH-1:0] data_b,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic                    busy_any
);
  logic signed [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nx;
  logic wr_ok, rsv_ok, va, vb;
  logic signed [WIDTH-1:0] rd_a, rd_b;
  function automatic logic ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction
  assign wr_ok  = wr_en && ok(wr_addr);
  assign rsv_ok = rsv_en && ok(rsv_addr);
  assign va     = ok(addr_a);
  assign vb     = ok(addr_b);
  // reserve is applied after the write clear so a same-cycle newer producer wins
  always_comb begin
    busy_nx = busy;
    if (wr_ok) busy_nx[wr_addr] = 1'b0;
    if (rsv_ok) busy_nx[rsv_addr] = 1'b1;
  end
  always_comb begin
    rd_a = !va ? '0 : (wr_ok && wr_addr == addr_a) ? wr_data : regs[addr_a];
    rd_b = !vb ? '0 : (wr_ok && wr_addr == addr_b) ? wr_data : regs[addr_b];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      data_a   <= '0;
      data_b   <= '0;
      busy_a   <= 1'b0;
      busy_b   <= 1'b0;
      busy_any <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy     <= busy_nx;
      data_a   <= rd_a;
      data_b   <= rd_b;
      busy_a   <= va && busy_nx[addr_a];
      busy_b   <= vb && busy_nx[addr_b];
      busy_any <= |busy_nx;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for a default regfile_sb and a ZERO_REG=1, DEPTH=6 variant
module tb_regfile_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] addr_a = '0, addr_b = '0, wr_addr = '0, rsv_addr = '0;
  logic wr_en = 1'b0, rsv_en = 1'b0;
  logic signed [15:0] wr_data = '0;
  logic signed [15:0] da0, db0, da1, db1;
  logic ba0, bb0, bany0, ba1, bb1, bany1;
  int cyc_n = 0, n_chk = 0, n_pass = 0;
  bit done = 1'b0;

  typedef struct {
    int cyc;
    bit z;
    logic [15:0] da, db;
    logic ba, bb, bany;
    string name;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .addr_a(addr_a), .addr_b(addr_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .data_a(da0), .data_b(db0), .busy_a(ba0), .busy_b(bb0), .busy_any(bany0));

  regfile_sb #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .addr_a(addr_a), .addr_b(addr_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .data_a(da1), .data_b(db1), .busy_a(ba1), .busy_b(bb1), .busy_any(bany1));

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra,
                       input logic [2:0] aa, input logic [2:0] ab);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; addr_a = aa; addr_b = ab;
  endtask

  task automatic expect_out(input string name, input bit z, input logic [15:0] da, input logic [15:0] db,
                            input logic ba, input logic bb, input logic bany);
    exp_t e;
    e.cyc = cyc_n + 1; e.z = z; e.da = da; e.db = db;
    e.ba = ba; e.bb = bb; e.bany = bany; e.name = name;
    q.push_back(e);
  endtask

  // monitor: outputs are sampled 1 time unit after each rising edge
  initial begin
    exp_t e;
    logic [34:0] act, want;
    forever begin
      @(posedge clk);
      cyc_n++;
      #1;
      while (q.size() > 0 && q[0].cyc == cyc_n) begin
        e = q.pop_front();
        act  = e.z ? {da1, db1, ba1, bb1, bany1} : {da0, db0, ba0, bb0, bany0};
        want = {e.da, e.db, e.ba, e.bb, e.bany};
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got da=%h db=%h ba=%b bb=%b bany=%b, want da=%h db=%h ba=%b bb=%b bany=%b",
                      e.name, act[34:19], act[18:3], act[2], act[1], act[0],
                      want[34:19], want[18:3], want[2], want[1], want[0]);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);               expect_out("reset_state", 0, 0, 0, 0, 0, 0);
    drive(1, 3, 16'h7FFF, 0, 0, 0, 0);        expect_out("wr_r3_read_r0", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 3);               expect_out("read_r3_max", 0, 16'h7FFF, 16'h7FFF, 0, 0, 0);
    drive(1, 7, 16'hFFFB, 0, 0, 7, 3);        expect_out("bypass_r7_neg", 0, 16'hFFFB, 16'h7FFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 7, 7);               expect_out("read_r7_neg", 0, 16'hFFFB, 16'hFFFB, 0, 0, 0);
    drive(1, 2, 16'h0011, 0, 0, 0, 0);        expect_out("wr_r2_old", 0, 0, 0, 0, 0, 0);
    drive(1, 2, 16'h1234, 0, 0, 2, 2);        expect_out("bypass_r2", 0, 16'h1234, 16'h1234, 0, 0, 0);
    drive(0, 0, 0, 1, 4, 4, 0);               expect_out("rsv_r4", 0, 0, 0, 1, 0, 1);
    drive(1, 4, 16'h0009, 0, 0, 4, 4);        expect_out("wb_r4_clear", 0, 16'h0009, 16'h0009, 0, 0, 0);
    drive(1, 5, 16'h00AB, 1, 5, 5, 5);        expect_out("rsv_wr_r5_same", 0, 16'h00AB, 16'h00AB, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 5, 3);               expect_out("r5_stays_busy", 0, 16'h00AB, 16'h7FFF, 1, 0, 1);
    drive(1, 6, 16'h0022, 0, 0, 6, 5);        expect_out("wr_idle_r6", 0, 16'h0022, 16'h00AB, 0, 1, 1);
    drive(1, 1, 16'h0101, 1, 0, 1, 0);        expect_out("rsv_r0_valid", 0, 16'h0101, 0, 0, 1, 1);
    // reset lands between the input change and the edge, so the r3 write is lost
    drive(1, 3, 16'h3333, 0, 0, 3, 3);        expect_out("reset_mid_write", 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);               expect_out("reset_held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 3'(i), 3'(7 - i)); expect_out($sformatf("post_reset_r%0d", i), 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 16'h0055, 1, 0, 0, 0);        expect_out("z_r0_wr_rsv", 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);               expect_out("z_r0_stays_zero", 1, 0, 0, 0, 0, 0);
    drive(1, 1, 16'h0011, 0, 0, 1, 5);        expect_out("z_wr_r1", 1, 16'h0011, 0, 0, 0, 0);
    drive(1, 7, 16'h0077, 1, 6, 1, 6);        expect_out("z_wr7_rsv6_ignored", 1, 16'h0011, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 6, 7);               expect_out("z_read_out_of_range", 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 5, 1);               expect_out("z_rsv_r5_top", 1, 0, 16'h0011, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    done = 1'b1;
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, want completion");
      $fatal(1, "timeout");
    end
  end
endmodule
